password_checker: RTL and testbench
===================================

# password_checker

Clocked, parametrised keypad password checker for the safe controller. It accumulates BCD digits from the keypad, compares the entry against a stored password of variable length on `*` submission, and supports password change while open. After repeated failures it locks out for a programmable period that survives power-off via `is_on`. It sits between the keypad decoder and the safe lock/LED drivers.

## Interface
- `DIGIT_W`, 4: bits per digit (8421 BCD).
- `MAX_LEN`, 6: maximum password/entry length in digits.
- `MIN_LEN`, 4: minimum length accepted when setting a new password.
- `MAX_FAIL`, 3: consecutive wrong submissions that trigger lockout.
- `LOCK_CYCLES`, 1024: lockout duration in clock cycles.
- `clk`  in  1  system clock, all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `is_on`  in  1  safe powered on; low forces OFF behaviour.
- `key_valid`  in  1  one-cycle strobe, `key_data` holds a digit.
- `key_data`  in  DIGIT_W  digit value.
- `star_pressed`  in  1  one-cycle submit strobe.
- `change_req`  in  1  one-cycle request to set a new password (honoured only in OPEN).
- `correct`  out  1  one-cycle pulse: submission matched.
- `wrong`  out  1  one-cycle pulse: submission mismatched, or invalid new-password length.
- `set_done`  out  1  one-cycle pulse: new password stored.
- `unlocked`  out  1  high while in OPEN.
- `changing`  out  1  high while in SET.
- `locked`  out  1  high while in LOCKOUT.
- `input_length`  out  $clog2(MAX_LEN+1)  digits currently buffered.
- `password_led`  out  MAX_LEN  thermometer of `input_length` (bit i = length > i).

## Operation
- States: OFF, ENTRY, OPEN, SET, LOCKOUT.
- Reset values: state OFF, stored password all zeros with length MAX_LEN, buffer cleared, length 0, fail count 0, timer 0. All outputs are 0.
- Priority each cycle: `is_on`=0 > `star_pressed` > `change_req` > `key_valid`. A lower-priority strobe in the same cycle is dropped.
- Digit append (ENTRY, SET only):
  - The digit is written at index `input_length` and the length increments.
  - When length = MAX_LEN, the digit is ignored with no error.
- OFF:
  - Buffer and length are cleared.
  - All strobes are ignored.
  - `is_on`=1 leads to ENTRY, or to LOCKOUT if the timer is nonzero.
- ENTRY, on star:
  - Match means length equals stored length and every digit below length is equal. Digits above length are don't-care.
  - On match: `correct` pulses, fail count goes to 0, next state OPEN.
  - On mismatch: `wrong` pulses and fail count increments. If the count reaches MAX_FAIL, the next state is LOCKOUT, the timer loads LOCK_CYCLES and the fail count goes to 0. Otherwise the state stays ENTRY.
  - The buffer is cleared in both cases.
- OPEN:
  - Keys are ignored.
  - `change_req` leads to SET with the buffer cleared.
  - Star leads to ENTRY (relock) with the buffer cleared and no pulse.
- SET, on star:
  - If MIN_LEN ≤ length ≤ MAX_LEN: store the buffer and length, pulse `set_done`.
  - Otherwise: pulse `wrong` and keep the old password.
  - Next state is OPEN in both cases, with the buffer cleared.
- LOCKOUT:
  - Keys, star and change requests are ignored.
  - The timer decrements every cycle, including while `is_on`=0.
  - When the timer reaches 0: go to ENTRY if `is_on`=1, else OFF.
- `is_on` falling: the next state is OFF from ENTRY, OPEN or SET.
  - LOCKOUT stays LOCKOUT; the timer keeps running and `locked` remains high.
  - The stored password and fail count are preserved.

## Timing
- All outputs are registered.
- A strobe sampled at edge N produces its result in the cycle after edge N: pulses, state flags and `input_length`.
- `correct`, `wrong` and `set_done` are exactly one cycle wide, are mutually exclusive, and are 0 in the cycle after reset release.
- Back-to-back strobes on consecutive cycles are all processed; no idle cycle is required.
- Lockout length: `locked` stays high for exactly LOCK_CYCLES cycles. The first cycle is the one following the failing star.
- Reset asserted mid-operation returns every register to its reset value immediately (asynchronously), including the stored password.

## Test plan
- Default password: after reset with `is_on`=1, enter 0,0,0,0,0,0 then star -> `correct` pulse 1 cycle after star, `unlocked`=1.
- Change password: in OPEN, `change_req`, keys 1,2,3,4, star -> `set_done`. Then star (relock), keys 1,2,3,4, star -> `correct`. Keys 1,2,3,4,5, star -> `wrong` (length mismatch).
- Invalid set: in SET, keys 1,2,3, star -> `wrong`, state OPEN, old password still accepted.
- Lockout (LOCK_CYCLES=8): three wrong submissions -> `locked`=1 for exactly 8 cycles. Keys and star during lockout are ignored. Dropping `is_on` mid-lockout does not shorten it. Afterwards the correct password gives `correct`.
- Overflow/priority: 7 keys, then `input_length`=6 and `password_led`=6'b111111. Key with star in the same cycle -> key dropped. `is_on`=0 with star in the same cycle -> OFF, no pulse.
- Async reset during SET with 3 digits buffered -> all outputs 0 immediately, and the password reverts to 000000.

Source files
------------

// File: rtl/password_checker.sv
// Keypad password checker: buffers BCD digits, verifies or changes the stored
// password on star, and locks out for a fixed period after repeated failures.
module password_checker #(
  parameter int DIGIT_W     = 4,
  parameter int MAX_LEN     = 6,
  parameter int MIN_LEN     = 4,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           is_on,
  input  logic                           key_valid,
  input  logic [DIGIT_W-1:0]             key_data,
  input  logic                           star_pressed,
  input  logic                           change_req,
  output logic                           correct,
  output logic                           wrong,
  output logic                           set_done,
  output logic                           unlocked,
  output logic                           changing,
  output logic                           locked,
  output logic [$clog2(MAX_LEN+1)-1:0]   input_length,
  output logic [MAX_LEN-1:0]             password_led
);

  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  localparam int TMR_W  = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [2:0] {
    S_OFF,
    S_ENTRY,
    S_OPEN,
    S_SET,
    S_LOCKOUT
  } state_e;

  state_e                            state_q, state_d;
  logic [MAX_LEN-1:0][DIGIT_W-1:0]   entry_q, entry_d;
  logic [LEN_W-1:0]                  len_q, len_d;
  logic [MAX_LEN-1:0][DIGIT_W-1:0]   pw_q, pw_d;
  logic [LEN_W-1:0]                  pw_len_q, pw_len_d;
  logic [FAIL_W-1:0]                 fail_q, fail_d;
  logic [TMR_W-1:0]                  timer_q, timer_d;
  logic                              correct_q, correct_d;
  logic                              wrong_q, wrong_d;
  logic                              set_done_q, set_done_d;
  logic                              unlocked_q, changing_q, locked_q;
  logic [MAX_LEN-1:0]                led_q, led_d;
  logic                              match;
  logic [FAIL_W-1:0]                 fail_inc;

  // Only digits below the entered length take part in the comparison.
  always_comb begin
    match = (len_q == pw_len_q);
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < len_q) && (entry_q[i] != pw_q[i])) begin
        match = 1'b0;
      end
    end
  end

  assign fail_inc = fail_q + FAIL_W'(1);

  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    len_d      = len_q;
    pw_d       = pw_q;
    pw_len_d   = pw_len_q;
    fail_d     = fail_q;
    timer_d    = timer_q;
    correct_d  = 1'b0;
    wrong_d    = 1'b0;
    set_done_d = 1'b0;

    unique case (state_q)
      S_OFF: begin
        entry_d = '0;
        len_d   = '0;
        if (is_on) begin
          state_d = (timer_q != '0) ? S_LOCKOUT : S_ENTRY;
        end
      end

      S_ENTRY: begin
        if (!is_on) begin
          state_d = S_OFF;
          entry_d = '0;
          len_d   = '0;
        end else if (star_pressed) begin
          entry_d = '0;
          len_d   = '0;
          if (match) begin
            correct_d = 1'b1;
            fail_d    = '0;
            state_d   = S_OPEN;
          end else begin
            wrong_d = 1'b1;
            if (fail_inc == FAIL_W'(MAX_FAIL)) begin
              fail_d  = '0;
              timer_d = TMR_W'(LOCK_CYCLES);
              state_d = S_LOCKOUT;
            end else begin
              fail_d = fail_inc;
            end
          end
        end else if (change_req) begin
          state_d = S_ENTRY;
        end else if (key_valid && (len_q != LEN_W'(MAX_LEN))) begin
          entry_d[len_q] = key_data;
          len_d          = len_q + LEN_W'(1);
        end
      end

      S_OPEN: begin
        if (!is_on) begin
          state_d = S_OFF;
          entry_d = '0;
          len_d   = '0;
        end else if (star_pressed) begin
          state_d = S_ENTRY;
          entry_d = '0;
          len_d   = '0;
        end else if (change_req) begin
          state_d = S_SET;
          entry_d = '0;
          len_d   = '0;
        end
      end

      S_SET: begin
        if (!is_on) begin
          state_d = S_OFF;
          entry_d = '0;
          len_d   = '0;
        end else if (star_pressed) begin
          if (len_q >= LEN_W'(MIN_LEN)) begin
            pw_d       = entry_q;
            pw_len_d   = len_q;
            set_done_d = 1'b1;
          end else begin
            wrong_d = 1'b1;
          end
          state_d = S_OPEN;
          entry_d = '0;
          len_d   = '0;
        end else if (change_req) begin
          state_d = S_SET;
        end else if (key_valid && (len_q != LEN_W'(MAX_LEN))) begin
          entry_d[len_q] = key_data;
          len_d          = len_q + LEN_W'(1);
        end
      end

      S_LOCKOUT: begin
        // The timer runs regardless of is_on so power cycling cannot shorten it.
        if (timer_q <= TMR_W'(1)) begin
          timer_d = '0;
          state_d = is_on ? S_ENTRY : S_OFF;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end

      default: begin
        state_d = S_OFF;
      end
    endcase
  end

  always_comb begin
    led_d = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      led_d[i] = (len_d > LEN_W'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_OFF;
      entry_q    <= '0;
      len_q      <= '0;
      pw_q       <= '0;
      pw_len_q   <= LEN_W'(MAX_LEN);
      fail_q     <= '0;
      timer_q    <= '0;
      correct_q  <= 1'b0;
      wrong_q    <= 1'b0;
      set_done_q <= 1'b0;
      unlocked_q <= 1'b0;
      changing_q <= 1'b0;
      locked_q   <= 1'b0;
      led_q      <= '0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      len_q      <= len_d;
      pw_q       <= pw_d;
      pw_len_q   <= pw_len_d;
      fail_q     <= fail_d;
      timer_q    <= timer_d;
      correct_q  <= correct_d;
      wrong_q    <= wrong_d;
      set_done_q <= set_done_d;
      unlocked_q <= (state_d == S_OPEN);
      changing_q <= (state_d == S_SET);
      locked_q   <= (state_d == S_LOCKOUT);
      led_q      <= led_d;
    end
  end

  assign correct      = correct_q;
  assign wrong        = wrong_q;
  assign set_done     = set_done_q;
  assign unlocked     = unlocked_q;
  assign changing     = changing_q;
  assign locked       = locked_q;
  assign input_length = len_q;
  assign password_led = led_q;

endmodule

// File: tb/tb_password_checker.sv
// Scoreboard bench for password_checker: stimulus pushes expected pulses,
// a monitor pops and compares them whenever the DUT pulses.
module tb_password_checker;

  localparam int DIGIT_W = 4;
  localparam int MAX_LEN = 6;

  // Pulse codes: {correct, wrong, set_done}
  localparam logic [2:0] P_NONE    = 3'b000;
  localparam logic [2:0] P_CORRECT = 3'b100;
  localparam logic [2:0] P_WRONG   = 3'b010;
  localparam logic [2:0] P_SET     = 3'b001;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               is_on;
  logic               key_valid;
  logic [DIGIT_W-1:0] key_data;
  logic               star_pressed;
  logic               change_req;
  logic               correct, wrong, set_done, unlocked, changing, locked;
  logic [2:0]         input_length;
  logic [MAX_LEN-1:0] password_led;

  int                 tests = 0;
  int                 fails = 0;
  logic [2:0]         expQ[$];
  int                 lockCnt;

  password_checker #(
    .DIGIT_W(DIGIT_W), .MAX_LEN(MAX_LEN), .MIN_LEN(4), .MAX_FAIL(3), .LOCK_CYCLES(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .is_on(is_on), .key_valid(key_valid),
    .key_data(key_data), .star_pressed(star_pressed), .change_req(change_req),
    .correct(correct), .wrong(wrong), .set_done(set_done), .unlocked(unlocked),
    .changing(changing), .locked(locked), .input_length(input_length),
    .password_led(password_led)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every pulse observed must match the oldest expected pulse.
  always @(negedge clk) begin
    logic [2:0] act;
    logic [2:0] exp;
    act = {correct, wrong, set_done};
    if (reset_n && act != P_NONE) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_pulse", {29'd0, act}, {29'd0, P_NONE});
      end else begin
        exp = expQ.pop_front();
        checkOutput("pulse", {29'd0, act}, {29'd0, exp});
      end
    end
  end

  // Drives one cycle of inputs starting just after a negedge; returns at the
  // next negedge, when the registered response is visible.
  task automatic applyStimulus(input logic kv, input logic [DIGIT_W-1:0] kd,
                               input logic st, input logic cr, input logic on);
    key_valid    = kv;
    key_data     = kd;
    star_pressed = st;
    change_req   = cr;
    is_on        = on;
    @(negedge clk);
    key_valid    = 1'b0;
    key_data     = '0;
    star_pressed = 1'b0;
    change_req   = 1'b0;
  endtask

  task automatic expectStimulus(input logic [2:0] code, input logic kv, input logic [DIGIT_W-1:0] kd,
                                input logic st, input logic cr, input logic on);
    if (code != P_NONE) expQ.push_back(code);
    applyStimulus(kv, kd, st, cr, on);
    #1;
    checkOutput("pulse_pending", expQ.size(), 0);
  endtask

  task automatic expectStar(input logic [2:0] code);
    expectStimulus(code, 1'b0, '0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic pressKey(input logic [DIGIT_W-1:0] d);
    applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic enterCode(input logic [23:0] code, input int n);
    for (int i = 0; i < n; i++) pressKey(code[4*(n-1-i) +: 4]);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0; is_on = 1'b0; key_valid = 1'b0; key_data = '0;
    star_pressed = 1'b0; change_req = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    checkOutput("reset_flags", {correct, wrong, set_done, unlocked, changing, locked}, 0);
    checkOutput("reset_len", input_length, 0);
    checkOutput("reset_led", password_led, 0);

    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("on_flags", {unlocked, changing, locked}, 0);

    // Default password 000000
    enterCode(24'h000000, 6);
    checkOutput("len6", input_length, 6);
    checkOutput("led6", password_led, 6'b111111);
    expectStar(P_CORRECT);
    checkOutput("open_default", unlocked, 1);
    checkOutput("len_cleared", input_length, 0);

    // Change to 1234
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
    checkOutput("changing", changing, 1);
    enterCode(24'h1234, 4);
    expectStar(P_SET);
    checkOutput("set_back_open", {unlocked, changing}, 2'b10);
    expectStar(P_NONE);
    checkOutput("relock", unlocked, 0);
    enterCode(24'h1234, 4);
    expectStar(P_CORRECT);
    checkOutput("open_new", unlocked, 1);
    expectStar(P_NONE);
    enterCode(24'h12345, 5);
    expectStar(P_WRONG);
    checkOutput("len_mismatch_closed", unlocked, 0);

    // Invalid set keeps the old password
    enterCode(24'h1234, 4);
    expectStar(P_CORRECT);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
    enterCode(24'h123, 3);
    expectStar(P_WRONG);
    checkOutput("bad_set_open", {unlocked, changing}, 2'b10);
    expectStar(P_NONE);
    enterCode(24'h1234, 4);
    expectStar(P_CORRECT);
    expectStar(P_NONE);

    // Lockout after three failures
    pressKey(4'd9); expectStar(P_WRONG);
    pressKey(4'd9); expectStar(P_WRONG);
    pressKey(4'd9); expectStar(P_WRONG);
    checkOutput("lock_start", locked, 1);
    lockCnt = locked ? 1 : 0;
    for (int k = 2; k <= 20; k++) begin
      case (k)
        2:       applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 1'b1);
        3:       applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        4:       applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        5:       applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        6:       applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
        7:       applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        default: applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
      endcase
      if (locked) lockCnt++;
      else break;
    end
    checkOutput("lock_len", lockCnt, 8);
    checkOutput("after_lock_len", input_length, 0);
    checkOutput("after_lock_open", unlocked, 0);
    enterCode(24'h1234, 4);
    expectStar(P_CORRECT);

    // Overflow and priority
    expectStar(P_NONE);
    enterCode(24'h123456, 6);
    pressKey(4'd7);
    checkOutput("overflow_len", input_length, 6);
    checkOutput("overflow_led", password_led, 6'b111111);
    expectStar(P_WRONG);
    enterCode(24'h1234, 4);
    expectStar(P_CORRECT);
    expectStar(P_NONE);
    enterCode(24'h123, 3);
    expectStimulus(P_WRONG, 1'b1, 4'd4, 1'b1, 1'b0, 1'b1);
    checkOutput("key_star_len", input_length, 0);
    enterCode(24'h12, 2);
    checkOutput("len2", input_length, 2);
    checkOutput("led2", password_led, 6'b000011);
    expectStimulus(P_NONE, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("off_flags", {unlocked, changing, locked}, 0);
    checkOutput("off_len", input_length, 0);
    checkOutput("off_led", password_led, 0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Async reset during SET
    enterCode(24'h1234, 4);
    expectStar(P_CORRECT);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
    enterCode(24'h123, 3);
    checkOutput("set_changing", changing, 1);
    checkOutput("set_len3", input_length, 3);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_flags", {correct, wrong, set_done, unlocked, changing, locked}, 0);
    checkOutput("async_len", input_length, 0);
    checkOutput("async_led", password_led, 0);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    enterCode(24'h1234, 4);
    expectStar(P_WRONG);
    enterCode(24'h000000, 6);
    expectStar(P_CORRECT);
    checkOutput("reverted_open", unlocked, 1);

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
